// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared encodings and types for the hazard/interrupt controller
package pipe_pkg;

  // ID-stage PC source encodings
  localparam logic [2:0] PCSRC_SEQ = 3'd0;
  localparam logic [2:0] PCSRC_BR  = 3'd1;
  localparam logic [2:0] PCSRC_J   = 3'd2;
  localparam logic [2:0] PCSRC_JR  = 3'd3;

  // Interrupt entry state machine
  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_PEND = 2'd1,
    S_BUSY = 2'd2
  } irq_state_t;

  // Kernel entry vector; a flushed IF/ID carries this as its PC_plus_4
  localparam logic [31:0] KERNEL_PC = 32'h80000000;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - pipeline stage fields in, register/PC controls out
interface pipe_hazard_ctrl_if;
  logic [4:0] ID_rs;
  logic [4:0] ID_rt;
  logic       ID_UseRs;
  logic       ID_UseRt;
  logic [2:0] ID_PCSrc;
  logic       ID_Kernel;
  logic       ID_Valid;
  logic       EX_MemRead;
  logic       EX_RegWrite;
  logic [4:0] EX_WriteAddress;
  logic       EX_BranchTaken;
  logic       MEM_MemRead;
  logic [4:0] MEM_WriteAddress;
  logic       PC_Write;
  logic       IF_ID_Write;
  logic       IF_ID_Flush;
  logic       ID_EX_Flush;
  logic       IRQ_Take;

  // Pipeline datapath side: supplies stage fields, consumes controls
  modport master (
    output ID_rs, ID_rt, ID_UseRs, ID_UseRt, ID_PCSrc, ID_Kernel, ID_Valid,
           EX_MemRead, EX_RegWrite, EX_WriteAddress, EX_BranchTaken,
           MEM_MemRead, MEM_WriteAddress,
    input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, IRQ_Take
  );

  // Hazard controller side
  modport slave (
    input  ID_rs, ID_rt, ID_UseRs, ID_UseRt, ID_PCSrc, ID_Kernel, ID_Valid,
           EX_MemRead, EX_RegWrite, EX_WriteAddress, EX_BranchTaken,
           MEM_MemRead, MEM_WriteAddress,
    output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, IRQ_Take
  );
endinterface

// File: rtl/pipe_hazard_ctrl_irq_sync.sv
// rtl/pipe_hazard_ctrl_irq_sync.sv - two-flop synchronizer for the external interrupt line
module irq_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;

  // Two-stage resynchronization of the asynchronous level into clk
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - hazard stall/flush and interrupt entry control; HAZARD_STATS_EN adds counters
module pipe_hazard_ctrl
  import pipe_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                IRQ,
  pipe_hazard_ctrl_if.slave   hz
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]         Stall_Count,
  output logic [31:0]         Flush_Count,
  output logic [15:0]         IRQ_Count
`endif
);

  logic       irq_s;
  logic       br;
  logic       jmp;
  logic       lu;
  logic       jr;
  logic       irq_take;
  irq_state_t state_q;
  irq_state_t state_d;

  irq_sync u_irq_sync (
    .clk   (clk),
    .reset (reset),
    .d     (IRQ),
    .q     (irq_s)
  );

  // Hazard conditions from current stage fields; $0 never hazards
  always_comb begin
    br  = hz.EX_BranchTaken;
    jmp = (hz.ID_PCSrc == PCSRC_J) || (hz.ID_PCSrc == PCSRC_JR);
    lu  = hz.EX_MemRead && (hz.EX_WriteAddress != 5'd0) &&
          ((hz.ID_UseRs && (hz.EX_WriteAddress == hz.ID_rs)) ||
           (hz.ID_UseRt && (hz.EX_WriteAddress == hz.ID_rt)));
    jr  = (hz.ID_PCSrc == PCSRC_JR) && (hz.ID_rs != 5'd0) &&
          ((hz.EX_RegWrite && (hz.EX_WriteAddress == hz.ID_rs)) ||
           (hz.MEM_MemRead && (hz.MEM_WriteAddress == hz.ID_rs)));
  end

  // Interrupt FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Interrupt FSM next state; a taken interrupt waits for IRQ to drop before re-arming
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (irq_s && !hz.ID_Kernel) state_d = S_PEND;
      end
      S_PEND: begin
        if (irq_take)   state_d = S_BUSY;
        else if (!irq_s) state_d = S_RUN;
      end
      S_BUSY: begin
        if (!irq_s) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  // Interrupt FSM output: take only a clean user-mode slot with no pipeline disturbance
  always_comb begin
    irq_take = (state_q == S_PEND) && hz.ID_Valid && !hz.ID_Kernel &&
               !br && !lu && !jr && !jmp;
  end

  // Prioritised pipeline register/PC controls
  always_comb begin
    hz.PC_Write    = 1'b1;
    hz.IF_ID_Write = 1'b1;
    hz.IF_ID_Flush = 1'b0;
    hz.ID_EX_Flush = 1'b0;
    hz.IRQ_Take    = irq_take;
    if (br) begin
      hz.IF_ID_Flush = 1'b1;
      hz.ID_EX_Flush = 1'b1;
    end else if (lu || jr) begin
      hz.PC_Write    = 1'b0;
      hz.IF_ID_Write = 1'b0;
      hz.ID_EX_Flush = 1'b1;
    end else if (jmp) begin
      hz.IF_ID_Flush = 1'b1;
    end else if (irq_take) begin
      hz.IF_ID_Flush = 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  // Saturating event counters for stalls, IF/ID flushes and interrupt entries
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Stall_Count <= 32'd0;
      Flush_Count <= 32'd0;
      IRQ_Count   <= 16'd0;
    end else begin
      if (!hz.PC_Write && (Stall_Count != 32'hFFFF_FFFF)) Stall_Count <= Stall_Count + 32'd1;
      if (hz.IF_ID_Flush && (Flush_Count != 32'hFFFF_FFFF)) Flush_Count <= Flush_Count + 32'd1;
      if (irq_take && (IRQ_Count != 16'hFFFF)) IRQ_Count <= IRQ_Count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  // expected vector order: {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, IRQ_Take}
  typedef struct {
    string      name;
    logic [4:0] exp;
  } sb_t;

  logic clk;
  logic reset;
  logic IRQ;
  int   n_cmp;
  int   n_bad;
  sb_t  sbq[$];
  sb_t  m_e;
  logic [4:0] m_act;

`ifdef HAZARD_STATS_EN
  logic [31:0] Stall_Count;
  logic [31:0] Flush_Count;
  logic [15:0] IRQ_Count;
`endif

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .IRQ   (IRQ),
    .hz    (bus)
`ifdef HAZARD_STATS_EN
    ,
    .Stall_Count (Stall_Count),
    .Flush_Count (Flush_Count),
    .IRQ_Count   (IRQ_Count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: sample mid-cycle and compare against the oldest expectation
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      m_e   = sbq.pop_front();
      m_act = {bus.PC_Write, bus.IF_ID_Write, bus.IF_ID_Flush, bus.ID_EX_Flush, bus.IRQ_Take};
      n_cmp++;
      if (m_act !== m_e.exp) begin
        n_bad++;
        $display("FAIL %s: got %b want %b", m_e.name, m_act, m_e.exp);
      end
    end
  end

  task automatic clr();
    bus.ID_rs = 5'd0;           bus.ID_rt = 5'd0;
    bus.ID_UseRs = 1'b0;        bus.ID_UseRt = 1'b0;
    bus.ID_PCSrc = PCSRC_SEQ;   bus.ID_Kernel = 1'b0;
    bus.ID_Valid = 1'b1;
    bus.EX_MemRead = 1'b0;      bus.EX_RegWrite = 1'b0;
    bus.EX_WriteAddress = 5'd0; bus.EX_BranchTaken = 1'b0;
    bus.MEM_MemRead = 1'b0;     bus.MEM_WriteAddress = 5'd0;
  endtask

  // Inputs are already applied; queue the expectation and advance to just after the next edge
  task automatic step(input string nm, input logic [4:0] e);
    sb_t s;
    s.name = nm;
    s.exp  = e;
    sbq.push_back(s);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string nm, input int n);
    for (int i = 0; i < n; i++) step(nm, 5'b11000);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    IRQ   = 1'b0;
    clr();
    @(posedge clk);
    #1;

    step("reset_idle", 5'b11000);
`ifdef HAZARD_STATS_EN
    n_cmp++;
    if ({Stall_Count, Flush_Count, IRQ_Count} !== 80'd0) begin
      n_bad++;
      $display("FAIL stats_reset: got %0d/%0d/%0d want 0/0/0", Stall_Count, Flush_Count, IRQ_Count);
    end
`endif
    reset = 1'b1;
    idle("post_reset", 2);

    // load-use via rs, then the load has moved on
    bus.EX_MemRead = 1'b1; bus.EX_WriteAddress = 5'd8; bus.ID_rs = 5'd8; bus.ID_UseRs = 1'b1;
    step("lu_rs", 5'b00010);
    bus.EX_MemRead = 1'b0; bus.EX_WriteAddress = 5'd0; bus.MEM_MemRead = 1'b1; bus.MEM_WriteAddress = 5'd8;
    step("lu_release", 5'b11000);
    clr();
    bus.EX_MemRead = 1'b1; bus.EX_WriteAddress = 5'd8; bus.ID_rs = 5'd3; bus.ID_rt = 5'd8;
    bus.ID_UseRs = 1'b1; bus.ID_UseRt = 1'b1;
    step("lu_rt", 5'b00010);
    clr();
    bus.EX_MemRead = 1'b1; bus.ID_UseRs = 1'b1;
    step("lu_r0", 5'b11000);
    clr();
    bus.EX_MemRead = 1'b1; bus.EX_WriteAddress = 5'd8; bus.ID_rs = 5'd8;
    step("lu_rs_unused", 5'b11000);
    bus.ID_UseRs = 1'b1; bus.EX_BranchTaken = 1'b1;
    step("br_over_lu", 5'b11110);
    clr();

    // jr operand hazards
    bus.ID_PCSrc = PCSRC_JR; bus.ID_rs = 5'd31; bus.ID_UseRs = 1'b1;
    bus.EX_RegWrite = 1'b1; bus.EX_WriteAddress = 5'd31;
    step("jr_ex_stall", 5'b00010);
    bus.EX_RegWrite = 1'b0; bus.EX_WriteAddress = 5'd0;
    step("jr_go", 5'b11100);
    bus.ID_rs = 5'd0; bus.EX_RegWrite = 1'b1;
    step("jr_r0", 5'b11100);
    bus.ID_rs = 5'd31; bus.EX_MemRead = 1'b1; bus.EX_RegWrite = 1'b1; bus.EX_WriteAddress = 5'd31;
    step("jr_load_1", 5'b00010);
    bus.EX_MemRead = 1'b0; bus.EX_RegWrite = 1'b0; bus.EX_WriteAddress = 5'd0;
    bus.MEM_MemRead = 1'b1; bus.MEM_WriteAddress = 5'd31;
    step("jr_load_2", 5'b00010);
    bus.MEM_MemRead = 1'b0; bus.MEM_WriteAddress = 5'd0;
    step("jr_load_go", 5'b11100);
    clr();
    bus.ID_PCSrc = PCSRC_J;
    step("j_flush", 5'b11100);
    bus.ID_PCSrc = PCSRC_BR;
    step("branch_in_id", 5'b11000);
    clr();

    // interrupt: take three cycles after rise, single pulse while held
    IRQ = 1'b1;
    idle("irq_sync", 3);
    step("irq_take", 5'b11101);
    idle("irq_held", 4);
    IRQ = 1'b0;
    idle("irq_drop", 4);
    IRQ = 1'b1;
    idle("irq2_sync", 3);
    step("irq2_take", 5'b11101);
    IRQ = 1'b0;
    idle("irq2_drop", 4);

    // kernel mode blocks, user mode releases
    IRQ = 1'b1; bus.ID_Kernel = 1'b1;
    idle("irq_kernel", 5);
    bus.ID_Kernel = 1'b0;
    step("kernel_exit", 5'b11000);
    step("kernel_take", 5'b11101);
    IRQ = 1'b0;
    idle("kernel_drop", 4);

    // branch coincident with pending: retried next cycle
    IRQ = 1'b1;
    idle("br_sync", 3);
    bus.EX_BranchTaken = 1'b1;
    step("br_blocks_take", 5'b11110);
    bus.EX_BranchTaken = 1'b0;
    step("br_retry_take", 5'b11101);
    IRQ = 1'b0;
    idle("br_drop", 4);

    // short request withdrawn while no valid instruction
    bus.ID_Valid = 1'b0;
    IRQ = 1'b1;
    idle("wd_high", 2);
    IRQ = 1'b0;
    idle("wd_low", 3);
    bus.ID_Valid = 1'b1;
    idle("wd_no_take", 3);

    // reset while pending
    IRQ = 1'b1;
    idle("rp_sync", 3);
    bus.EX_MemRead = 1'b1; bus.EX_WriteAddress = 5'd8; bus.ID_rs = 5'd8; bus.ID_UseRs = 1'b1;
    step("rp_hold_lu", 5'b00010);
    clr();
    reset = 1'b0;
    #1;
    step("rp_reset_no_take", 5'b11000);
`ifdef HAZARD_STATS_EN
    n_cmp++;
    if ({Stall_Count, Flush_Count, IRQ_Count} !== 80'd0) begin
      n_bad++;
      $display("FAIL stats_midreset: got %0d/%0d/%0d want 0/0/0", Stall_Count, Flush_Count, IRQ_Count);
    end
`endif
    bus.EX_MemRead = 1'b1; bus.EX_WriteAddress = 5'd8; bus.ID_rs = 5'd8; bus.ID_UseRs = 1'b1;
    step("rp_hazard_in_reset", 5'b00010);
    clr();
    reset = 1'b1;
    idle("rp_resync", 3);
    step("rp_take", 5'b11101);
    IRQ = 1'b0;
    idle("rp_drop", 3);

    #20;
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and interrupt controller for the 5-stage MIPS pipeline. It generates the write-enable and flush controls consumed by the IF/ID and ID/EX pipeline registers and the PC register, covering load-use stalls, jr operand stalls, jump and branch flushes, and external interrupt entry. Hazard decisions are combinational from current stage fields; interrupt entry is governed by a registered state machine with an input synchronizer.

## Interface
- No parameters.
- clk  in  1  core clock
- reset  in  1  reset, asynchronous, active-low; clock clk
- IRQ  in  1  external interrupt, level, asynchronous to clk
- ID_rs, ID_rt  in  5  source registers of ID instruction
- ID_UseRs, ID_UseRt  in  1  ID instruction reads rs / rt
- ID_PCSrc  in  3  ID PC source: 0 seq, 1 branch, 2 j/jal, 3 jr/jalr
- ID_Kernel  in  1  ID_PC_plus_4[31]; 1 = kernel mode
- ID_Valid  in  1  ID holds a real (non-bubble) instruction
- EX_MemRead, EX_RegWrite  in  1  EX stage controls
- EX_WriteAddress  in  5  EX destination register
- EX_BranchTaken  in  1  branch in EX resolved taken
- MEM_MemRead  in  1  MEM stage load
- MEM_WriteAddress  in  5  MEM destination register
- PC_Write  out  1  PC update enable
- IF_ID_Write  out  1  IF/ID load enable
- IF_ID_Flush  out  1  IF/ID clear (bubble, PC_plus_4=0x80000000)
- ID_EX_Flush  out  1  ID/EX clear
- IRQ_Take  out  1  one-cycle pulse: ID instruction replaced by interrupt entry

## Operation
- Conditions, evaluated each cycle:
  - BR = EX_BranchTaken.
  - JMP = ID_PCSrc ∈ {2,3}.
  - LU = EX_MemRead & EX_WriteAddress≠0 & ((ID_UseRs & EX_WriteAddress==ID_rs) | (ID_UseRt & EX_WriteAddress==ID_rt)).
  - JR = ID_PCSrc==3 & ID_rs≠0 & ((EX_RegWrite & EX_WriteAddress==ID_rs) | (MEM_MemRead & MEM_WriteAddress==ID_rs)).
- Priority (highest first):
  - BR: IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1, IF_ID_Write=1. Overrides all stalls.
  - LU or JR: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, IF_ID_Flush=0.
  - JMP: IF_ID_Flush=1, all else default.
  - IRQ_Take: IF_ID_Flush=1, PC_Write=1.
  - Default: PC_Write=1, IF_ID_Write=1, flushes 0.
- Interrupt FSM states:
  - S_RUN: irq_s=1 & ~ID_Kernel → S_PEND.
  - S_PEND: IRQ_Take = ID_Valid & ~ID_Kernel & ~BR & ~LU & ~JR & ~JMP. If IRQ_Take → S_BUSY. If irq_s=0 → S_RUN (request withdrawn, no take).
  - S_BUSY: irq_s=0 → S_RUN. IRQ is level-sensitive; re-arm requires deassertion.
- irq_s is IRQ through a 2-flop synchronizer.
- Register $0 never creates a hazard.

## Timing
- Hazard outputs are combinational and same-cycle; no added latency.
- IRQ rises before edge k: irq_s=1 after edge k+1; S_PEND after edge k+2; earliest IRQ_Take is the cycle following edge k+2.
- IRQ_Take is asserted for exactly 1 cycle per interrupt.
- LU stalls exactly 1 cycle. JR stalls 1 cycle for an EX producer and 1 more if it is a load; max 2 cycles.
- Reset (async, mid-operation included): FSM=S_RUN, sync flops=0, counters=0, IRQ_Take=0. Hazard outputs continue to follow inputs.
- BR coincident with S_PEND: no take; retried the next cycle.

## Configuration
- HAZARD_STATS_EN defined: adds outputs Stall_Count[31:0] (cycles with PC_Write=0), Flush_Count[31:0] (cycles with IF_ID_Flush=1), IRQ_Count[15:0] (IRQ_Take pulses). All saturating, reset to 0.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package pipe_pkg holds:
  - PCSrc encodings (PCSRC_SEQ=0, PCSRC_BR=1, PCSRC_J=2, PCSRC_JR=3).
  - FSM state typedef (S_RUN, S_PEND, S_BUSY).
  - KERNEL_PC=32'h80000000.
- Sub-module irq_sync contains the 2-flop synchronizer, async active-low reset.

## Test plan
- lw $8 in EX (EX_MemRead=1, EX_WriteAddress=8), ID add using rs=8 → PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1 for 1 cycle, then default.
- EX_BranchTaken=1 with LU also true → IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1.
- jr $31 in ID with EX_RegWrite=1, EX_WriteAddress=31 → 1-cycle stall; same case with EX_WriteAddress=0 and ID_rs=0 → no stall.
- IRQ rises, ID user-mode and valid, no hazards → IRQ_Take one pulse 3 cycles later with IF_ID_Flush=1; IRQ held high → no second pulse until IRQ drops and rises again.
- IRQ high while ID_Kernel=1 → no IRQ_Take; ID_Kernel drops → take proceeds.
- Assert reset in S_PEND → IRQ_Take=0, FSM=S_RUN; with HAZARD_STATS_EN, counters read 0.
